// File: rtl/dmem.sv
// dmem: single-port, read-first, byte-write-enable data memory for the LSU path.
// One request per cycle; write data lands at the clock edge, read data for the
// addressed word (pre-write contents) is registered on the same edge.

package dmem_pkg;

    // LSU request as presented to the data memory each cycle.
    typedef struct packed {
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic [3:0]  p_bytemask;
        logic        p_wren;
        logic        valid;
    } o_lsu_s;

endpackage

module dmem
    import dmem_pkg::*;
#(
    parameter int unsigned DMEM_W = 16
) (
    input  logic        clk,
    input  logic        rst_n_compare,
    input  o_lsu_s      i_o_lsu,
    output logic [31:0] o_p_rdata
);

    localparam int unsigned NumWords = 2 ** (DMEM_W - 2);

    logic [31:0]       mem [NumWords];
    logic [DMEM_W-3:0] word_idx;
    logic [31:0]       rdata_q;
    logic              unused_bits;

    // Low two address bits and everything above DMEM_W drop out here, so
    // unaligned and out-of-range addresses simply alias onto a word.
    assign word_idx = i_o_lsu.p_addr[DMEM_W-1:2];

    // valid deliberately does not gate anything; the LSU clears p_wren itself.
    assign unused_bits = ^{i_o_lsu.valid, i_o_lsu.p_addr};

    // Read-first port: rdata samples the old word while the masked lanes are
    // overwritten. Reset clears only the read register and blocks the write at
    // that edge; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n_compare) begin
        if (!rst_n_compare) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= mem[word_idx];
            if (i_o_lsu.p_wren) begin
                for (int i = 0; i < 4; i++) begin
                    if (i_o_lsu.p_bytemask[i]) begin
                        mem[word_idx][8*i +: 8] <= i_o_lsu.p_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign o_p_rdata = rdata_q;

endmodule

// File: tb/tb_dmem.sv
// tb_dmem: randomized + directed scoreboard bench for dmem against a
// byte-addressed reference memory.

module tb_dmem;
    import dmem_pkg::*;

    localparam int unsigned DW = 16;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  known;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n_compare = 1'b1;
    o_lsu_s      req;
    logic [31:0] o_p_rdata;

    int checks = 0;
    int errors = 0;

    // Reference: byte address (already folded modulo 2^DW) -> byte value.
    logic [7:0] ref_mem [int];
    exp_t       sb [$];

    always #5 clk = ~clk;

    dmem #(.DMEM_W(DW)) dut (
        .clk           (clk),
        .rst_n_compare (rst_n_compare),
        .i_o_lsu       (req),
        .o_p_rdata     (o_p_rdata)
    );

    function automatic int word_base(input logic [31:0] addr);
        int a;
        a = int'(addr % (32'd1 << DW));
        return a - (a % 4);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request; predict the read result from the model before
    // applying the store to the model.
    task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, input logic wren, input logic valid);
        exp_t e;
        int   base;
        @(negedge clk);
        req.p_addr     = addr;
        req.p_wdata    = wdata;
        req.p_bytemask = mask;
        req.p_wren     = wren;
        req.valid      = valid;
        base    = word_base(addr);
        e.data  = 32'h0;
        e.known = 4'b0;
        e.name  = name;
        for (int i = 0; i < 4; i++) begin
            if (ref_mem.exists(base + i)) begin
                e.data[8*i +: 8] = ref_mem[base + i];
                e.known[i]       = 1'b1;
            end
        end
        sb.push_back(e);
        if (wren) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) ref_mem[base + i] = wdata[8*i +: 8];
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req.p_wren = 1'b0;
        req.valid  = 1'b0;
    endtask

    // Monitor: one result per issued request, one edge after it was presented.
    always @(posedge clk) begin
        exp_t e;
        logic ok;
        #1;
        if (rst_n_compare && sb.size() > 0) begin
            e  = sb.pop_front();
            ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (e.known[i] && (o_p_rdata[8*i +: 8] !== e.data[8*i +: 8])) ok = 1'b0;
            end
            if (e.known != 4'b0) begin
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (checked lanes %b)",
                             e.name, o_p_rdata, e.data, e.known);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        req = '0;

        // Asynchronous reset: output clears before any clock edge.
        #2 rst_n_compare = 1'b0;
        #1 check32("reset_async", o_p_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 check32("reset_hold", o_p_rdata, 32'h0);
        @(negedge clk);
        rst_n_compare = 1'b1;

        // Back-to-back full-word writes to one word: output lags by one write.
        for (int k = 0; k < 6; k++) begin
            issue("b2b_addr100", 32'd100, $urandom, 4'hF, 1'b1, 1'($urandom));
        end

        // Write then read.
        issue("wr_40", 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
        issue("rd_40", 32'h40, 32'h0, 4'h0, 1'b0, 1'b1);
        issue("rd_44_unwritten", 32'h44, 32'h0, 4'h0, 1'b0, 1'b1);

        // Byte mask merge and empty mask.
        issue("bm_full", 32'h80, 32'h11223344, 4'hF, 1'b1, 1'b1);
        issue("bm_0101", 32'h80, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b1);
        issue("bm_rd", 32'h80, 32'h0, 4'h0, 1'b0, 1'b1);
        issue("bm_0000", 32'h80, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b1);
        issue("bm_rd2", 32'h80, 32'h0, 4'h0, 1'b0, 1'b1);

        // Alignment and aliasing.
        issue("alias_wr", 32'h00000102, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
        issue("alias_rd_100", 32'h00000100, 32'h0, 4'h0, 1'b0, 1'b1);
        issue("alias_rd_10100", 32'h00010100, 32'h0, 4'h0, 1'b0, 1'b0);

        // Random traffic over a small word set with random alias/offset bits.
        for (int k = 0; k < 300; k++) begin
            addr = ($urandom << DW) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            issue("random", addr, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset mid-stream: array survives, write at a reset edge is dropped.
        issue("pre_rst_wr", 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b1);
        idle();
        @(posedge clk);
        #2 rst_n_compare = 1'b0;
        #1 check32("reset_mid_async", o_p_rdata, 32'h0);
        req.p_addr     = 32'h20;
        req.p_wdata    = 32'hFFFFFFFF;
        req.p_bytemask = 4'hF;
        req.p_wren     = 1'b1;
        @(posedge clk);
        #1 check32("reset_mid_hold", o_p_rdata, 32'h0);
        @(negedge clk);
        req.p_wren = 1'b0;
        @(negedge clk);
        rst_n_compare = 1'b1;
        issue("post_rst_rd_20", 32'h20, 32'h0, 4'h0, 1'b0, 1'b1);
        issue("post_rst_rd_80", 32'h80, 32'h0, 4'h0, 1'b0, 1'b1);

        idle();
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem.md
# dmem

Synchronous data memory for the superscalar core's load/store path. It accepts one LSU request per cycle, carried as an `o_lsu_s` package. Each cycle it performs a byte-masked word write and returns the registered read data of the addressed word one cycle later, with read-first semantics. It sits behind the LSU and replaces a cache/bus in the integrated core.

## Interface
Parameters:
- DMEM_W, default 16: byte-address width.
  - Capacity is 2^DMEM_W bytes, organised as 2^(DMEM_W-2) 32-bit words.

Ports:
- clk, input, 1: clock, rising-edge.
- rst_n_compare, input, 1: reset, asynchronous, active-low. Clock is clk.
- i_o_lsu, input, o_lsu_s: LSU request with these fields:
  - p_addr[31:0]: byte address.
  - p_wdata[31:0]: store data.
  - p_bytemask[3:0]: per-byte write enable; bit i enables byte lane i (bits 8i+7:8i).
  - p_wren: 1 = store.
  - valid: request valid.
- o_p_rdata, output, 32: registered read data of the addressed word.

## Operation
- Word index is p_addr[DMEM_W-1:2].
  - p_addr[1:0] and p_addr[31:DMEM_W] are ignored; there is no misalignment trap and no out-of-range trap.
  - Addresses alias modulo 2^DMEM_W.
- Write condition: p_wren = 1 at a rising clk edge while out of reset.
  - valid does not gate writes. The LSU is responsible for deasserting p_wren on invalid slots.
  - On write, for each lane i with p_bytemask[i] = 1: mem[idx] byte i <= p_wdata byte i. Unmasked lanes keep their old value.
  - p_bytemask = 0000 with p_wren = 1 writes nothing.
  - No data alignment or shifting is done inside the block. The LSU supplies lane-aligned data and mask: sb uses 0001 with data in byte 0, sh uses 0011, sw uses 1111.
- Read: every rising edge, o_p_rdata <= mem[idx] as it was *before* this edge's write (read-first).
  - A load and a store to the same word in the same cycle return the old word.
  - The read register is updated regardless of valid and p_wren.
- No sign/zero extension is done here; the LSU extracts and extends bytes and halfwords from o_p_rdata.
- Memory array contents are not reset.
  - Uninitialised words read as X in simulation.
  - An optional $readmemh initial load is permitted under a synthesis-off guard.
- Implement the array as inferable block RAM with a byte-write-enable, single-port, read-first template.

## Timing
- Reset (rst_n_compare low, asynchronous): o_p_rdata = 32'h0 immediately. The array is untouched. After release, the first update happens at the next rising edge.
- Read latency is 1 cycle: the address presented before edge k produces data on o_p_rdata after edge k, and that data holds until edge k+1.
- Write takes effect at edge k. A read of the same word issued for edge k+1 returns the new data after edge k+1.
- Back-to-back writes to the same address with mask 1111: after edge k, o_p_rdata equals the data written at edge k-1.
- Reset asserted mid-stream: o_p_rdata clears at once. Writes in progress at the reset edge are not performed. Previously written array contents are retained.
- There is no handshake or stall; one request is accepted every cycle.

## Test plan
- Reset: assert rst_n_compare low -> o_p_rdata = 0x00000000 asynchronously, without waiting for a clk edge.
- Repeated full-word writes to addr 100 (mask 1111, wren 1, random valid), data D0, D1, D2… one per edge -> after edge k, o_p_rdata = D(k-1).
  - After the first edge following reset, the output is the prior content of word 25.
- Write then read:
  - Write 0xDEADBEEF to 0x40; next cycle read 0x40 with wren 0 -> o_p_rdata = 0xDEADBEEF one edge later.
  - Read 0x44 (never written) returns X.
- Byte mask:
  - Write 0x11223344 to 0x80 with mask 1111.
  - Then write 0xAABBCCDD with mask 0101.
  - Read 0x80 -> 0x11BB33DD.
  - Mask 0000 with wren 1 -> word unchanged.
- Address aliasing and alignment:
  - Write 0xCAFEF00D to 0x00000102; read 0x00000100 -> 0xCAFEF00D.
  - Read 0x00010100 with DMEM_W = 16 -> 0xCAFEF00D.
- Reset mid-operation: write 0x12345678 to 0x20, pulse rst_n_compare low, then read 0x20 -> o_p_rdata is 0 during reset and 0x12345678 after the first post-reset read edge.
